ldpc_array_encoder: RTL and testbench
=====================================

Name: ldpc_array_encoder

Overview:
- Systematic quasi-cyclic LDPC encoder. It is the transmit-side counterpart of LDPC_Decoder and uses the same block geometry: K info block-columns, J=3 block-rows (one per permutation layer), and circulant size L.
- Accepts one K-bit info word per handshake. It forwards each info word and accumulates circulant-shifted parity in J banks of L bits.
- After L info words it streams L parity words, then starts the next frame.
- Sits between the frame source and the channel model that feeds int_in of the decoder testbench.

Parameters:
L, 32, circulant size (words per info phase and per parity phase)
ADDR_WIDTH, 5, log2(L)
K, 6, info block-columns (bits per info word)
J, 3, block-rows / parity banks; constraint J <= K

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  info word valid
in_ready  out  1  encoder can accept an info word
in_data  in  K  bit j = info bit of block-column j at position t (t = word index in frame)
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the output word
out_data  out  K  info word, or parity word {zeros, p[J-1][m] .. p[0][m]}
out_parity  out  1  1 when out_data carries a parity word
out_sof  out  1  first word of codeword (info t=0)
out_eof  out  1  last word of codeword (parity m=L-1)

Behaviour:
- Reset (async assert, sync release):
  - state=INFO, count=0, all accumulators 0.
  - out_valid=0, out_data=0, out_parity=0, out_sof=0, out_eof=0.
  - in_ready follows its equation and is 1 out of reset.
- Shift definition: s(r,j) = (r*j) mod L, for r in 0..J-1 and j in 0..K-1.
- Check m of row r covers info bit (j, (m + s(r,j)) mod L) for every j, plus parity bit p[r][m]. The parity part is identity, so p[r][m] = XOR of the covered info bits.
- Output register: a single stage. It may load when !out_valid || out_ready ("slot free").
- State INFO:
  - in_ready = slot free.
  - Accept (in_valid && in_ready) at word t: in the same edge, for every r and j, acc[r][(t - s(r,j)) mod L] ^= in_data[j].
  - Same edge loads out_data = in_data, out_parity=0, out_sof=(t==0). Latency is 1 cycle.
  - count increments. On accepting t=L-1: count wraps to 0 and state goes to PARITY.
  - Index arithmetic is modulo L on ADDR_WIDTH bits, with natural wrap when L = 2^ADDR_WIDTH.
- State PARITY:
  - in_ready=0.
  - When slot free, load word m = count: out_data[J-1:0] = {acc[J-1][m],..,acc[0][m]}, upper bits 0, out_parity=1, out_eof=(m==L-1).
  - After loading m=L-1: clear all accumulators, count=0, state goes to INFO.
  - The first info word of the next frame may be accepted on the cycle after the eof word is loaded, with no dead cycles beyond that.
- Handshake rules:
  - While out_valid && !out_ready, out_data and all flags hold stable and nothing new is loaded.
  - in_valid low in INFO stalls without state change.
  - out_valid drops only on a transfer with no new load.
- Simultaneous events: if one input word toggles several positions of the same bank, all XORs apply in the same edge. Duplicate indices only occur for the same r with different j; they XOR cumulatively.
- Reset mid-frame: the partial frame is discarded, and the next accepted word is t=0 with out_sof.

Decomposition:
- Package ldpc_enc_pkg holds:
  - L, K, J and ADDR_WIDTH defaults.
  - Function shift(r,j) returning (r*j)%L.
  - State enum {INFO, PARITY}.
- One sub-module, parity_acc_bank, instantiated J times, parameterised by row r:
  - holds L bits;
  - on acc_en, XORs K input bits at addresses (t - s(r,j)) mod L;
  - on clr, zeroes all L bits;
  - provides combinational read of bit m.

Test Plan:
1. All-zero frame with out_ready=1 → 32 info words of 0 then 32 parity words of 0. out_sof on word 0, out_eof on parity word 31.
2. Single bit in_data=6'b000001 at t=0 (column 0, all shifts 0) → parity word 0 = 6'b000111, and all other parity words 0.
3. in_data=6'b000010 at t=5 (column 1, shifts 0/1/2) → parity word 5 = 001, word 4 = 010, word 3 = 100 (bits [2:0]), all others 0.
4. Wrap-around: in_data=6'b000100 at t=0 (column 2, shifts 0/2/4) → p0[0]=1, p1[30]=1, p2[28]=1, i.e. word 0 = 001, word 30 = 010, word 28 = 100.
5. Backpressure: random out_ready and in_valid gaps over 3 back-to-back random frames → output equals the reference model. Words hold stable while stalled, no word is lost or duplicated, and in_ready=0 throughout PARITY.
6. Reset mid-operation: assert reset at info t=17, then again at parity m=9 → outputs clear immediately. The next frame encodes as in test 2, proving the accumulators cleared.

Source files
------------

// File: rtl/ldpc_enc_pkg.sv
// Shared geometry, state type and circulant shift helper for the QC-LDPC encoder.
package ldpc_enc_pkg;

    localparam int unsigned L          = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned K          = 6;
    localparam int unsigned J          = 3;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(L - 1);

    typedef enum logic {StInfo, StParity} state_e;

    // Circulant shift of block-row r, block-column j.
    function automatic logic [ADDR_WIDTH-1:0] shift(input int unsigned r, input int unsigned j);
        return ADDR_WIDTH'((r * j) % L);
    endfunction

endpackage

// File: rtl/parity_acc_bank.sv
// One parity bank (block-row R): L accumulator bits toggled by circulant-shifted info bits.
module parity_acc_bank
    import ldpc_enc_pkg::*;
#(
    parameter int unsigned R = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  acc_en_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] t_i,
    input  logic [K-1:0]          bits_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_bit_o
);

    logic [L-1:0]          acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] idx;

    // Several columns may hit the same address; the sequential XOR keeps them cumulative.
    always_comb begin
        acc_d = acc_q;
        idx   = '0;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            for (int j = 0; j < K; j++) begin
                idx        = ADDR_WIDTH'((32'(t_i) + L - 32'(shift(R, j))) % L);
                acc_d[idx] = acc_d[idx] ^ bits_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign rd_bit_o = acc_q[rd_addr_i];

endmodule

// File: rtl/ldpc_array_encoder.sv
// Systematic QC-LDPC encoder: forwards L info words, then streams L parity words per frame.
module ldpc_array_encoder
    import ldpc_enc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] out_data,
    output logic         out_parity,
    output logic         out_sof,
    output logic         out_eof
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [K-1:0]          out_data_q, out_data_d;
    logic                  out_parity_q, out_parity_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;

    logic         slot_free, accept, par_load, last_word, clr;
    logic [J-1:0] par_bits;

    for (genvar r = 0; r < J; r++) begin : gen_bank
        parity_acc_bank #(
            .R(r)
        ) u_bank (
            .clk_i    (clk),
            .rst_i    (reset),
            .acc_en_i (accept),
            .clr_i    (clr),
            .t_i      (count_q),
            .bits_i   (in_data),
            .rd_addr_i(count_q),
            .rd_bit_o (par_bits[r])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInfo;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_parity_d = out_parity_q;
        out_sof_d    = out_sof_q;
        out_eof_d    = out_eof_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = in_data;
            out_parity_d = 1'b0;
            out_sof_d    = (count_q == '0);
            out_eof_d    = 1'b0;
            count_d      = last_word ? '0 : count_q + ADDR_WIDTH'(1);
            if (last_word) state_d = StParity;
        end else if (par_load) begin
            out_valid_d          = 1'b1;
            out_data_d           = '0;
            out_data_d[J-1:0]    = par_bits;
            out_parity_d         = 1'b1;
            out_sof_d            = 1'b0;
            out_eof_d            = last_word;
            count_d              = last_word ? '0 : count_q + ADDR_WIDTH'(1);
            if (last_word) state_d = StInfo;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        slot_free  = !out_valid_q || out_ready;
        in_ready   = (state_q == StInfo) && slot_free;
        accept     = in_valid && in_ready;
        par_load   = (state_q == StParity) && slot_free;
        last_word  = (count_q == LastIdx);
        clr        = par_load && last_word;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        out_parity = out_parity_q;
        out_sof    = out_sof_q;
        out_eof    = out_eof_q;
    end

endmodule

// File: tb/tb_ldpc_array_encoder.sv
// Bench for ldpc_array_encoder: parity-check-equation model, directed frames, stalls and resets.
module tb_ldpc_array_encoder;
    import ldpc_enc_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [K-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [K-1:0] out_data;
    logic         out_parity, out_sof, out_eof;

    ldpc_array_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_parity(out_parity),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [K-1:0] data;
        logic         parity;
        logic         sof;
        logic         eof;
    } word_t;

    word_t        exp_q[$];
    logic [K-1:0] info_buf [L];
    logic [K-1:0] par_seen [L];
    logic [K-1:0] frame    [L];
    logic [K-1:0] lit      [L];
    int           model_t, par_idx;
    bit           in_parity, prev_stall, rand_ready;
    word_t        prev_w;
    int           checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: parity from the check equations over the whole stored frame.
    task automatic model_accept(input logic [K-1:0] w);
        logic [K-1:0] pw;
        info_buf[model_t] = w;
        exp_q.push_back(word_t'{data: w, parity: 1'b0, sof: (model_t == 0), eof: 1'b0});
        if (model_t == L - 1) begin
            for (int m = 0; m < L; m++) begin
                pw = '0;
                for (int r = 0; r < J; r++)
                    for (int j = 0; j < K; j++)
                        pw[r] = pw[r] ^ info_buf[(m + r * j) % L][j];
                exp_q.push_back(word_t'{data: pw, parity: 1'b1, sof: 1'b0, eof: (m == L - 1)});
            end
            in_parity = 1'b1;
            model_t   = 0;
        end else begin
            model_t++;
        end
    endtask

    initial begin : monitor
        word_t w_now, e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                model_t    = 0;
                par_idx    = 0;
                in_parity  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                w_now = word_t'{data: out_data, parity: out_parity, sof: out_sof, eof: out_eof};
                if (prev_stall) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_hold", 32'(w_now), 32'(prev_w));
                end
                prev_stall = out_valid && !out_ready;
                prev_w     = w_now;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got %0h expected none", w_now);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", 32'(w_now), 32'(e));
                    end
                    if (out_sof) par_idx = 0;
                    if (out_parity && par_idx < L) begin
                        par_seen[par_idx] = out_data;
                        par_idx++;
                    end
                end
                if (in_parity) begin
                    if (out_valid && out_parity && out_eof) in_parity = 1'b0;
                    else check("in_ready_parity", 32'(in_ready), 32'd0);
                end
                if (in_valid && in_ready) model_accept(in_data);
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    task automatic send_word(input logic [K-1:0] w, input int gap_pct);
        int n;
        bit got;
        if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n   = 0;
        got = 1'b0;
        while (!got && n < 500) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 500 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_words(input int n, input int gap_pct);
        for (int t = 0; t < n; t++) send_word(frame[t], gap_pct);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_vectors();
        for (int m = 0; m < L; m++) begin
            frame[m] = '0;
            lit[m]   = '0;
        end
    endtask

    task automatic check_lit(input string name);
        for (int m = 0; m < L; m++)
            check($sformatf("%s_p%0d", name, m), 32'(par_seen[m]), 32'(lit[m]));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_data"}, 32'(out_data), 32'd0);
        check({name, "_out_parity"}, 32'(out_parity), 32'd0);
        check({name, "_out_sof"}, 32'(out_sof), 32'd0);
        check({name, "_out_eof"}, 32'(out_eof), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_outputs(name);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic directed(input string name);
        rand_ready = 1'b0;
        send_words(L, 0);
        drain();
        check_lit(name);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        checks = 0;
        errors = 0;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        clear_vectors();
        directed("zero");

        clear_vectors();
        frame[0] = 6'b000001;
        lit[0]   = 6'b000111;
        directed("col0");

        clear_vectors();
        frame[5] = 6'b000010;
        lit[5]   = 6'b000001;
        lit[4]   = 6'b000010;
        lit[3]   = 6'b000100;
        directed("col1");

        clear_vectors();
        frame[0] = 6'b000100;
        lit[0]   = 6'b000001;
        lit[30]  = 6'b000010;
        lit[28]  = 6'b000100;
        directed("wrap");

        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < L; t++) frame[t] = K'($urandom_range(0, (1 << K) - 1));
            send_words(L, 30);
        end
        drain();

        rand_ready = 1'b0;
        for (int t = 0; t < L; t++) frame[t] = K'($urandom_range(0, (1 << K) - 1));
        send_words(17, 0);
        do_reset("rst_info");
        send_words(L, 0);
        begin
            int n = 0;
            while (par_idx < 9 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check("reach_parity9", 32'(par_idx >= 9), 32'd1);
        end
        do_reset("rst_parity");

        clear_vectors();
        frame[0] = 6'b000001;
        lit[0]   = 6'b000111;
        directed("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
